// File: rtl/pc_stack_pkg.sv
// Shared types and helpers for the program-counter stack.
// Operation encoding, priority decode and depth-width helper.
package pc_stack_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_PUSH,
        OP_POP,
        OP_CLEAR
    } op_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a counter that must hold 0..d inclusive.
    function automatic int depth_w(input int d);
        return clog2(d + 1);
    endfunction

    function automatic op_e op_decode(
        input logic clear,
        input logic pop,
        input logic push,
        input logic load,
        input logic inc
    );
        op_e op;
        priority case (1'b1)
            clear:   op = OP_CLEAR;
            pop:     op = OP_POP;
            push:    op = OP_PUSH;
            load:    op = OP_LOAD;
            inc:     op = OP_INC;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Bus between the counter and the return-address LIFO.
// The counter side is master; the storage side is slave.
interface pc_stack_if #(
    parameter int DATA_SIZE = 16,
    parameter int DW        = 4
);

    logic                 push;
    logic                 pop;
    logic                 clr;
    logic [DATA_SIZE-1:0] wdata;
    logic [DATA_SIZE-1:0] rdata;
    logic [DW-1:0]        depth;

    modport master (
        output push,
        output pop,
        output clr,
        output wdata,
        input  rdata,
        input  depth
    );

    modport slave (
        input  push,
        input  pop,
        input  clr,
        input  wdata,
        output rdata,
        output depth
    );

endinterface

// File: rtl/pc_stack_lifo_stack.sv
// Return-address LIFO: registered depth, unreset storage.
// rdata always presents the current top entry.
module lifo_stack
    import pc_stack_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_stack_if.slave   bus
);

    localparam int DW = depth_w(DEPTH);
    localparam int AW = clog2(DEPTH);
    localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DW-1:0]        depth_q;
    logic [DW-1:0]        depth_d;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [AW-1:0]        top_idx;

    assign waddr   = AW'(depth_q);
    assign top_idx = AW'(depth_q - DW'(1));

    always_comb begin
        depth_d = depth_q;
        we      = 1'b0;
        if (bus.clr) begin
            depth_d = '0;
        end else if (bus.pop && depth_q != '0) begin
            depth_d = depth_q - DW'(1);
        end else if (bus.push && depth_q != FULL_CNT) begin
            we      = 1'b1;
            depth_d = depth_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Storage carries no reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= bus.wdata;
        end
    end

    assign bus.rdata = (depth_q == '0) ? '0 : mem_q[top_idx];
    assign bus.depth = depth_q;

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack and sticky error flags.
// One operation per edge: clear > pop > push > load > inc > hold.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int                   DATA_SIZE   = 16,
    parameter int                   DEPTH       = 8,
    parameter logic [DATA_SIZE-1:0] RESET_VALUE = '0
) (
`ifdef USE_POWER_PINS
    inout  wire                          vccd1,
    inout  wire                          vssd1,
`endif
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [DATA_SIZE-1:0]         in,
    input  logic                         load,
    input  logic                         inc,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic                         err_clr,
    output logic [DATA_SIZE-1:0]         out,
    output logic [depth_w(DEPTH)-1:0]    depth,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int DW = depth_w(DEPTH);
    localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

    pc_stack_if #(
        .DATA_SIZE (DATA_SIZE),
        .DW        (DW)
    ) stk ();

    lifo_stack #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_lifo (
        .clk   (clock),
        .rst_n (reset_n),
        .bus   (stk)
    );

    op_e                  op;
    logic [DATA_SIZE-1:0] out_q;
    logic [DATA_SIZE-1:0] out_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 unf_q;
    logic                 unf_d;
    logic                 st_push;
    logic                 st_pop;
    logic                 st_clr;
    logic                 is_empty;
    logic                 is_full;

    assign op       = op_decode(clear, pop, push, load, inc);
    assign is_empty = (stk.depth == '0);
    assign is_full  = (stk.depth == FULL_CNT);

    always_comb begin
        out_d   = out_q;
        // A flag raised on this edge overrides err_clr below.
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;
        st_push = 1'b0;
        st_pop  = 1'b0;
        st_clr  = 1'b0;
        unique case (op)
            OP_CLEAR: begin
                out_d  = RESET_VALUE;
                ovf_d  = 1'b0;
                unf_d  = 1'b0;
                st_clr = 1'b1;
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    out_d  = stk.rdata;
                    st_pop = 1'b1;
                end
            end
            OP_PUSH: begin
                out_d = in;
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    st_push = 1'b1;
                end
            end
            OP_LOAD: out_d = in;
            OP_INC:  out_d = out_q + DATA_SIZE'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= RESET_VALUE;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign stk.push  = st_push;
    assign stk.pop   = st_pop;
    assign stk.clr   = st_clr;
    assign stk.wdata = out_q + DATA_SIZE'(1);

    assign out       = out_q;
    assign depth     = stk.depth;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack with a queue-based reference model.
// Every falling edge compares all outputs against the model.
module tb_pc_stack;

    localparam logic [15:0] RV = 16'h0010;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] din = '0;
    logic        ld = 1'b0;
    logic        ic = 1'b0;
    logic        ps = 1'b0;
    logic        pp = 1'b0;
    logic        cl = 1'b0;
    logic        ec = 1'b0;

    logic [15:0] out;
    logic [3:0]  depth;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [15:0] m_out = RV;
    logic [15:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    pc_stack #(
        .DATA_SIZE   (16),
        .DEPTH       (8),
        .RESET_VALUE (RV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (din),
        .load      (ld),
        .inc       (ic),
        .push      (ps),
        .pop       (pp),
        .clear     (cl),
        .err_clr   (ec),
        .out       (out),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: stack is a queue, flags follow the stated rules.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_out = RV;
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (ec) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (cl) begin
                m_out = RV;
                m_q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else if (pp) begin
                if (m_q.size() == 0) m_unf = 1'b1;
                else m_out = m_q.pop_back();
            end else if (ps) begin
                if (m_q.size() < 8) m_q.push_back(m_out + 16'd1);
                else m_ovf = 1'b1;
                m_out = din;
            end else if (ld) begin
                m_out = din;
            end else if (ic) begin
                m_out = m_out + 16'd1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("mdl_out", 32'(out), 32'(m_out));
            chk("mdl_depth", 32'(depth), 32'(m_q.size()));
            chk("mdl_empty", 32'(empty), 32'(m_q.size() == 0));
            chk("mdl_full", 32'(full), 32'(m_q.size() == 8));
            chk("mdl_ovf", 32'(overflow), 32'(m_ovf));
            chk("mdl_unf", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic op(input logic l, input logic i, input logic pu,
                      input logic po, input logic c, input logic e,
                      input logic [15:0] d);
        ld = l; ic = i; ps = pu; pp = po; cl = c; ec = e; din = d;
        @(posedge clock);
        #1;
        ld = 0; ic = 0; ps = 0; pp = 0; cl = 0; ec = 0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", 32'(out), 32'(RV));
        chk("rst_depth", 32'(depth), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_flags", 32'({overflow, underflow}), 0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        repeat (3) op(0, 1, 0, 0, 0, 0, '0);
        chk("inc3_out", 32'(out), 32'h13);
        chk("inc3_empty", 32'(empty), 1);

        op(1, 0, 0, 0, 0, 0, 16'hFFFF);
        op(0, 1, 0, 0, 0, 0, '0);
        chk("wrap_out", 32'(out), 0);
        chk("wrap_flags", 32'({overflow, underflow}), 0);

        op(1, 0, 0, 0, 0, 0, 16'h0100);
        op(0, 0, 1, 0, 0, 0, 16'h2000);
        chk("call1_out", 32'(out), 32'h2000);
        chk("call1_depth", 32'(depth), 1);
        op(0, 0, 1, 0, 0, 0, 16'h3000);
        chk("call2_out", 32'(out), 32'h3000);
        chk("call2_depth", 32'(depth), 2);
        op(0, 0, 0, 1, 0, 0, '0);
        chk("ret1_out", 32'(out), 32'h2001);
        chk("ret1_depth", 32'(depth), 1);
        op(0, 0, 0, 1, 0, 0, '0);
        chk("ret2_out", 32'(out), 32'h0101);
        chk("ret2_depth", 32'(depth), 0);

        for (int k = 0; k < 8; k++) op(0, 0, 1, 0, 0, 0, 16'h0040 + 16'(k));
        chk("fill_full", 32'(full), 1);
        op(0, 0, 1, 0, 0, 0, 16'h0050);
        chk("ovf_out", 32'(out), 32'h50);
        chk("ovf_depth", 32'(depth), 8);
        chk("ovf_flag", 32'(overflow), 1);
        op(0, 0, 1, 0, 0, 1, 16'h0051);
        chk("ovf_vs_clr", 32'(overflow), 1);
        op(0, 0, 0, 0, 0, 1, '0);
        chk("errclr_ovf", 32'(overflow), 0);
        op(0, 0, 0, 0, 0, 0, '0);
        chk("hold_out", 32'(out), 32'h51);
        op(0, 0, 0, 1, 0, 0, '0);
        chk("pop_top", 32'(out), 32'h47);
        chk("pop_depth", 32'(depth), 7);
        op(0, 0, 0, 0, 1, 0, '0);
        chk("clr_depth", 32'(depth), 0);

        op(0, 1, 0, 0, 0, 0, '0);
        op(0, 0, 0, 1, 0, 0, '0);
        chk("unf_out", 32'(out), 32'h11);
        chk("unf_flag", 32'(underflow), 1);
        op(0, 0, 0, 0, 0, 1, '0);
        chk("errclr_unf", 32'(underflow), 0);

        op(0, 0, 1, 0, 0, 0, 16'h0200);
        op(0, 0, 1, 1, 0, 0, 16'h0300);
        chk("pushpop_out", 32'(out), 32'h12);
        chk("pushpop_depth", 32'(depth), 0);

        op(1, 0, 0, 0, 0, 0, 16'h0077);
        op(0, 1, 0, 0, 1, 0, '0);
        chk("clrinc_out", 32'(out), 32'(RV));
        op(1, 1, 0, 0, 0, 0, 16'h0055);
        chk("loadinc_out", 32'(out), 32'h55);

        for (int k = 1; k <= 3; k++) op(0, 0, 1, 0, 0, 0, 16'(k));
        chk("pre_rst_depth", 32'(depth), 3);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'(RV));
        chk("arst_depth", 32'(depth), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        #1 reset_n = 1'b1;
        op(0, 1, 0, 0, 0, 0, '0);
        chk("post_rst_inc", 32'(out), 32'(RV) + 1);

        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter DATA_SIZE, default 16, SHALL set the width of the program-counter value and of each stack entry.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of return-address stack entries (legal range 2..64).
REQ-003 Parameter RESET_VALUE, default 0, SHALL set the program-counter value loaded on reset and on clear.
REQ-004 Ports SHALL be exactly as below; the design has one clock, and reset is asynchronous and active-low.
- clock  in  1  main clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- vccd1, vssd1  inout  1  power pins, present only under USE_POWER_PINS
- in  in  DATA_SIZE  jump/call target
- load  in  1  jump: out <= in
- inc  in  1  advance: out <= out+1
- push  in  1  call: push out+1 onto the stack, then out <= in
- pop  in  1  return: out <= top of stack, then pop
- clear  in  1  synchronous clear of the counter, stack and flags
- err_clr  in  1  clears the sticky error flags
- out  out  DATA_SIZE  current program counter (registered)
- depth  out  clog2(DEPTH+1)  number of valid stack entries
- empty, full  out  1  depth==0 / depth==DEPTH
- overflow, underflow  out  1  sticky error flags

Function
REQ-005 On each rising edge, exactly one operation SHALL take effect, selected by priority: clear > pop > push > load > inc > hold.
REQ-006 Hold (no request asserted) SHALL keep out, the stack and the flags unchanged.
REQ-007 inc SHALL set out to (out+1) mod 2^DATA_SIZE; the value 2^DATA_SIZE-1 wraps to 0 without setting any flag.
REQ-008 load SHALL set out to in.
REQ-009 push with full==0 SHALL write (out+1) mod 2^DATA_SIZE to entry[depth], increment depth, and set out to in, all on the same edge.
REQ-010 push with full==1 SHALL set out to in, leave the stack and depth unchanged, and set overflow.
REQ-011 pop with empty==0 SHALL set out to entry[depth-1] and decrement depth on the same edge.
REQ-012 pop with empty==1 SHALL leave out and depth unchanged and set underflow.
REQ-013 Simultaneous push and pop SHALL execute pop only; the push is dropped silently.
REQ-014 clear SHALL set out to RESET_VALUE, depth to 0, and overflow and underflow to 0.
REQ-015 err_clr SHALL zero overflow and underflow on the next edge.
- A flag-setting event on the same edge as err_clr wins: the flag reads 1.
REQ-016 out, depth, empty and full SHALL be registered.
- empty and full SHALL be derived from the registered depth with no extra latency.
- Every operation SHALL be visible on out one cycle after its request edge.
REQ-017 Stack entries at index >= depth SHALL be don't-care and SHALL never drive out.

Reset
REQ-018 While reset_n==0, asynchronously and independent of clock, the block SHALL force:
- out=RESET_VALUE, depth=0, empty=1, full=0, overflow=0, underflow=0
REQ-019 Stack storage SHALL NOT be reset.
REQ-020 Assertion of reset_n mid-operation SHALL abort that operation; the first edge after deassertion SHALL perform the operation requested on that edge.

Structure
REQ-021 A shared package/header pc_stack_pkg SHALL hold:
- the operation encoding (OP_HOLD, OP_INC, OP_LOAD, OP_PUSH, OP_POP, OP_CLEAR)
- the priority-decode function
- the depth-width helper (clog2)
REQ-022 The return-address storage SHALL be a sub-module lifo_stack (DATA_SIZE, DEPTH) with push/pop/wdata/rdata/depth ports; pc_stack owns the counter, priority decode and error flags.

Verification
REQ-023 Reset and increment: reset with RESET_VALUE=0x0010, then 3 cycles of inc -> out=0x0013, depth=0, empty=1.
REQ-024 Wrap: load in=0xFFFF, then inc -> out=0x0000, overflow=0, underflow=0.
REQ-025 Call/return: out=0x0100, push in=0x2000, push in=0x3000, pop, pop.
- out sequence: 0x2000, 0x3000, 0x2001, 0x0101
- depth sequence: 1, 2, 1, 0
REQ-026 Overflow: DEPTH=8, 9 pushes.
- 9th push: out=in, depth stays 8, full=1, overflow=1.
- err_clr -> overflow=0.
REQ-027 Underflow and priority:
- pop while empty -> out unchanged, underflow=1.
- push+pop together with depth=1 -> pop only, depth=0.
- clear+inc -> out=RESET_VALUE.
REQ-028 Async reset: assert reset_n low between clock edges while depth=3 -> outputs reach their reset values before the next edge; release -> the next inc gives RESET_VALUE+1.
